reg_file_unit: RTL and testbench

- Clocked, parametrised register file for the processor datapath.
- Provides:
  - a general register array with 2 read ports and 1 write-back port;
  - HI/LO special registers;
  - a status register (SR) loaded from an operand compare;
  - a pending-write scoreboard that flags read-after-write hazards for multi-cycle ALU ops (multiply/divide).
- Sits between decode and the ALU. All state updates occur on the clock edge.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 59 +++++
 rtl/reg_file_unit.sv | 152 +++++++++++++++
 tb/tb_reg_file_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register file: SR flag positions, default sizes
// and the index-width helper used to size register index ports.
package rf_pkg;

  localparam int SR_Z = 3;
  localparam int SR_N = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;

  function automatic int idx_w(input int num_regs);
    return $clog2(num_regs);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy bit per register, issue gating and read hazard detect.
// Combinational hazard/ready outputs; busy vector updates on the clock edge, no stalls of its own.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int IDX_W = idx_w(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rs_idx,
  input  logic             rs_ok,
  input  logic [IDX_W-1:0] rt_idx,
  input  logic             rt_ok,
  input  logic             wb_en,
  input  logic [IDX_W-1:0] wb_idx,
  input  logic             wb_ok,
  input  logic             issue_en,
  input  logic [IDX_W-1:0] issue_idx,
  input  logic             issue_ok,
  output logic             issue_ready,
  output logic             rd_hazard
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                rs_block;
  logic                rt_block;
  logic                issue_take;

  // A same-cycle write-back to the busy register resolves it through the bypass.
  assign rs_block = rs_ok && busy[rs_idx] && !(wb_en && (wb_idx == rs_idx));
  assign rt_block = rt_ok && busy[rt_idx] && !(wb_en && (wb_idx == rt_idx));

  assign rd_hazard   = rd_en && (rs_block || rt_block);
  assign issue_ready = !(issue_ok && busy[issue_idx]) || (wb_en && (wb_idx == issue_idx));
  assign issue_take  = issue_en && issue_ready && issue_ok;

  always_comb begin
    busy_nxt = busy;
    if (wb_en && wb_ok) begin
      busy_nxt[wb_idx] = 1'b0;
    end
    // Set after clear so issue and write-back to one index leave it busy.
    if (issue_take) begin
      busy_nxt[issue_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/reg_file_unit.sv
// Register file with 2 read ports, write-back bypass, HI/LO, compare-driven SR and scoreboard.
// Reads return one cycle after acceptance; a read hitting a busy register is refused (rd_hazard) and must be held.
module reg_file_unit
  import rf_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int INIT_DESC = 1,
  localparam int IDX_W = idx_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rs_idx,
  input  logic [IDX_W-1:0]  rt_idx,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rd_valid,
  output logic              rd_hazard,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  input  logic              cmp_en,
  input  logic              sr_clr,
  output logic [3:0]        sr,
  input  logic              issue_en,
  input  logic [IDX_W-1:0]  issue_idx,
  output logic              issue_ready
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] diff;
  logic [3:0]        cmp_flags;
  logic              rs_ok;
  logic              rt_ok;
  logic              wb_ok;
  logic              issue_ok;
  logic              rd_accept;

  // Index range checks only matter when NUM_REGS leaves unused index codes.
  generate
    if ((1 << IDX_W) == NUM_REGS) begin : g_full_range
      assign rs_ok    = 1'b1;
      assign rt_ok    = 1'b1;
      assign wb_ok    = 1'b1;
      assign issue_ok = 1'b1;
    end else begin : g_part_range
      localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(NUM_REGS);
      assign rs_ok    = {1'b0, rs_idx} < LIMIT;
      assign rt_ok    = {1'b0, rt_idx} < LIMIT;
      assign wb_ok    = {1'b0, wb_idx} < LIMIT;
      assign issue_ok = {1'b0, issue_idx} < LIMIT;
    end
  endgenerate

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_en       (rd_en),
    .rs_idx      (rs_idx),
    .rs_ok       (rs_ok),
    .rt_idx      (rt_idx),
    .rt_ok       (rt_ok),
    .wb_en       (wb_en),
    .wb_idx      (wb_idx),
    .wb_ok       (wb_ok),
    .issue_en    (issue_en),
    .issue_idx   (issue_idx),
    .issue_ok    (issue_ok),
    .issue_ready (issue_ready),
    .rd_hazard   (rd_hazard)
  );

  assign rd_accept = rd_en && !rd_hazard;

  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs_ok) begin
      rs_val = (wb_en && (wb_idx == rs_idx)) ? wb_data : regs[rs_idx];
    end
    if (rt_ok) begin
      rt_val = (wb_en && (wb_idx == rt_idx)) ? wb_data : regs[rt_idx];
    end
  end

  assign diff = rs_val - rt_val;

  // Flags describe rs - rt: C is the unsigned borrow, V the signed overflow.
  always_comb begin
    cmp_flags        = '0;
    cmp_flags[SR_Z]  = (rs_val == rt_val);
    cmp_flags[SR_N]  = diff[DATA_W-1];
    cmp_flags[SR_C]  = (rs_val < rt_val);
    cmp_flags[SR_V]  = (rs_val[DATA_W-1] != rt_val[DATA_W-1]) &&
                       (diff[DATA_W-1] != rs_val[DATA_W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (INIT_DESC != 0) ? DATA_W'(NUM_REGS - 1 - i) : '0;
      end
    end else if (wb_en && wb_ok) begin
      regs[wb_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_data  <= '0;
      rt_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rs_data <= rs_val;
        rt_data <= rt_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (hilo_we) begin
      hi_out <= hi_in;
      lo_out <= lo_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (rd_accept && cmp_en) begin
      sr <= cmp_flags;
    end else if (sr_clr) begin
      sr <= '0;
    end
  end

endmodule

// File: tb/tb_reg_file_unit.sv
// Bench for reg_file_unit: an 8-register and a 6-register instance share stimulus and
// are checked every cycle against a behavioural model, plus directed literal checks.
module tb_reg_file_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en, wb_en, hilo_we, cmp_en, sr_clr, issue_en;
  logic [2:0]  rs_idx, rt_idx, wb_idx, issue_idx;
  logic [15:0] wb_data, hi_in, lo_in;

  logic [15:0] rs_o [2];
  logic [15:0] rt_o [2];
  logic [15:0] hi_o [2];
  logic [15:0] lo_o [2];
  logic [3:0]  sr_o [2];
  logic        vld_o [2];
  logic        hz_o [2];
  logic        ir_o [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  reg_file_unit #(.DATA_W(16), .NUM_REGS(8), .INIT_DESC(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rs_idx(rs_idx), .rt_idx(rt_idx),
    .rs_data(rs_o[0]), .rt_data(rt_o[0]), .rd_valid(vld_o[0]), .rd_hazard(hz_o[0]),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data), .hilo_we(hilo_we),
    .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_o[0]), .lo_out(lo_o[0]),
    .cmp_en(cmp_en), .sr_clr(sr_clr), .sr(sr_o[0]), .issue_en(issue_en),
    .issue_idx(issue_idx), .issue_ready(ir_o[0])
  );

  reg_file_unit #(.DATA_W(16), .NUM_REGS(6), .INIT_DESC(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rs_idx(rs_idx), .rt_idx(rt_idx),
    .rs_data(rs_o[1]), .rt_data(rt_o[1]), .rd_valid(vld_o[1]), .rd_hazard(hz_o[1]),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data), .hilo_we(hilo_we),
    .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_o[1]), .lo_out(lo_o[1]),
    .cmp_en(cmp_en), .sr_clr(sr_clr), .sr(sr_o[1]), .issue_en(issue_en),
    .issue_idx(issue_idx), .issue_ready(ir_o[1])
  );

  // Reference state for both instances.
  int          nr [2] = '{8, 6};
  logic [15:0] m_reg [2][8];
  bit          m_busy [2][8];
  logic [15:0] m_rs [2];
  logic [15:0] m_rt [2];
  logic [15:0] m_hi [2];
  logic [15:0] m_lo [2];
  logic [3:0]  m_sr [2];
  bit          m_vld [2];

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] opnd(input int k, input int idx);
    if (idx >= nr[k]) return 16'h0;
    if (wb_en && int'(wb_idx) == idx) return wb_data;
    return m_reg[k][idx];
  endfunction

  function automatic bit blocked(input int k, input int idx);
    return (idx < nr[k]) && m_busy[k][idx] && !(wb_en && int'(wb_idx) == idx);
  endfunction

  function automatic bit hazard(input int k);
    return rd_en && (blocked(k, int'(rs_idx)) || blocked(k, int'(rt_idx)));
  endfunction

  function automatic bit ready(input int k);
    bit held;
    held = (int'(issue_idx) < nr[k]) && m_busy[k][issue_idx];
    return !held || (wb_en && wb_idx == issue_idx);
  endfunction

  // {Z,N,C,V} of a-b, overflow taken from exact signed integer arithmetic.
  function automatic logic [3:0] flags(input logic [15:0] a, input logic [15:0] b);
    int          sa, sb, df;
    logic [15:0] d;
    sa = int'($signed(a));
    sb = int'($signed(b));
    df = sa - sb;
    d  = a - b;
    return {a == b, d[15], a < b, (df > 32767) || (df < -32768)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 8; i++) begin
          m_reg[k][i]  <= (i < nr[k]) ? 16'(nr[k] - 1 - i) : 16'h0;
          m_busy[k][i] <= 1'b0;
        end
        m_rs[k] <= '0; m_rt[k] <= '0; m_hi[k] <= '0; m_lo[k] <= '0;
        m_sr[k] <= '0; m_vld[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_vld[k] <= rd_en && !hazard(k);
        if (rd_en && !hazard(k)) begin
          m_rs[k] <= opnd(k, int'(rs_idx));
          m_rt[k] <= opnd(k, int'(rt_idx));
        end
        if (rd_en && !hazard(k) && cmp_en)
          m_sr[k] <= flags(opnd(k, int'(rs_idx)), opnd(k, int'(rt_idx)));
        else if (sr_clr)
          m_sr[k] <= '0;
        if (hilo_we) begin
          m_hi[k] <= hi_in;
          m_lo[k] <= lo_in;
        end
        if (wb_en && int'(wb_idx) < nr[k]) begin
          m_reg[k][wb_idx]  <= wb_data;
          m_busy[k][wb_idx] <= 1'b0;
        end
        if (issue_en && ready(k) && int'(issue_idx) < nr[k])
          m_busy[k][issue_idx] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("rs_data", k, rs_o[k], m_rs[k]);
        chk("rt_data", k, rt_o[k], m_rt[k]);
        chk("rd_valid", k, 16'(vld_o[k]), 16'(m_vld[k]));
        chk("hi_out", k, hi_o[k], m_hi[k]);
        chk("lo_out", k, lo_o[k], m_lo[k]);
        chk("sr", k, 16'(sr_o[k]), 16'(m_sr[k]));
        chk("rd_hazard", k, 16'(hz_o[k]), 16'(hazard(k)));
        chk("issue_ready", k, 16'(ir_o[k]), 16'(ready(k)));
      end
    end
  end

  task automatic idle();
    rd_en = 0; wb_en = 0; hilo_we = 0; cmp_en = 0; sr_clr = 0; issue_en = 0;
    rs_idx = 0; rt_idx = 0; wb_idx = 0; issue_idx = 0;
    wb_data = 0; hi_in = 0; lo_in = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_rs", k, rs_o[k], 16'h0);
      chk("rst_valid", k, 16'(vld_o[k]), 16'h0);
      chk("rst_hi", k, hi_o[k], 16'h0);
      chk("rst_sr", k, 16'(sr_o[k]), 16'h0);
    end
    rst_n = 1'b1;

    // Default contents, including an out-of-range read on the 6-register instance.
    rd_en = 1; rs_idx = 0; rt_idx = 7;
    step(); idle();
    chk("init_valid", 0, 16'(vld_o[0]), 16'h1);
    chk("init_rs", 0, rs_o[0], 16'h0007);
    chk("init_rt", 0, rt_o[0], 16'h0000);
    chk("init_rs", 1, rs_o[1], 16'h0005);
    chk("init_rt_oor", 1, rt_o[1], 16'h0000);

    // Write bypass and later readback.
    rd_en = 1; rs_idx = 3; rt_idx = 3; wb_en = 1; wb_idx = 3; wb_data = 16'h00AA;
    step(); idle();
    chk("bypass_rs", 0, rs_o[0], 16'h00AA);
    rd_en = 1; rs_idx = 3; rt_idx = 1;
    step(); idle();
    chk("readback_rs", 0, rs_o[0], 16'h00AA);
    chk("readback_rt", 0, rt_o[0], 16'h0006);

    // Compare flags.
    wb_en = 1; wb_idx = 1; wb_data = 16'h8000;
    step(); idle();
    rd_en = 1; cmp_en = 1; rs_idx = 1; rt_idx = 2; wb_en = 1; wb_idx = 2; wb_data = 16'h0001;
    step(); idle();
    chk("sr_ovf", 0, 16'(sr_o[0]), 16'h0001);
    wb_en = 1; wb_idx = 4; wb_data = 16'h0002;
    step(); idle();
    rd_en = 1; cmp_en = 1; rs_idx = 4; rt_idx = 5; wb_en = 1; wb_idx = 5; wb_data = 16'h0005;
    step(); idle();
    chk("sr_borrow", 0, 16'(sr_o[0]), 16'h0006);
    chk("sr_borrow", 1, 16'(sr_o[1]), 16'h0006);
    rd_en = 1; cmp_en = 1; rs_idx = 4; rt_idx = 4;
    step(); idle();
    chk("sr_equal", 0, 16'(sr_o[0]), 16'h0008);

    // Hazard on a busy register, resolved by a same-cycle write-back.
    issue_en = 1; issue_idx = 2;
    #1 chk("issue_ready_free", 0, 16'(ir_o[0]), 16'h1);
    step(); idle();
    rd_en = 1; rs_idx = 2; rt_idx = 0;
    #1 chk("hazard_set", 0, 16'(hz_o[0]), 16'h1);
    step();
    chk("hazard_novalid", 0, 16'(vld_o[0]), 16'h0);
    chk("hazard_hold", 0, rs_o[0], 16'h0002);
    wb_en = 1; wb_idx = 2; wb_data = 16'h1234;
    #1 chk("hazard_resolved", 0, 16'(hz_o[0]), 16'h0);
    step(); idle();
    chk("resolved_rs", 0, rs_o[0], 16'h1234);
    chk("resolved_valid", 0, 16'(vld_o[0]), 16'h1);
    issue_idx = 2;
    #1 chk("busy_cleared", 0, 16'(ir_o[0]), 16'h1);

    // Re-issue to a busy register, then issue+wb in one cycle.
    issue_en = 1; issue_idx = 2;
    step(); idle();
    issue_en = 1; issue_idx = 2;
    #1 chk("reissue_blocked", 0, 16'(ir_o[0]), 16'h0);
    step(); idle();
    issue_en = 1; issue_idx = 2; wb_en = 1; wb_idx = 2; wb_data = 16'h5555;
    #1 chk("issue_wb_ready", 0, 16'(ir_o[0]), 16'h1);
    step(); idle();
    issue_idx = 2;
    #1 chk("issue_wb_busy", 0, 16'(ir_o[0]), 16'h0);

    // Asynchronous reset mid-cycle with a HI/LO load pending.
    step();
    hilo_we = 1; hi_in = 16'h1111; lo_in = 16'h2222; issue_idx = 2;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_hi", 0, hi_o[0], 16'h0);
    chk("arst_lo", 0, lo_o[0], 16'h0);
    chk("arst_sr", 0, 16'(sr_o[0]), 16'h0);
    chk("arst_rs", 0, rs_o[0], 16'h0);
    chk("arst_busy", 0, 16'(ir_o[0]), 16'h1);
    idle();
    step();
    rst_n = 1'b1;
    rd_en = 1; rs_idx = 3; rt_idx = 2;
    step(); idle();
    chk("post_rst_rs", 0, rs_o[0], 16'h0004);
    chk("post_rst_rs", 1, rs_o[1], 16'h0002);

    // Index 7 on the 6-register instance: write ignored, reads zero, never busy.
    rd_en = 1; rs_idx = 7; rt_idx = 0; wb_en = 1; wb_idx = 7; wb_data = 16'hBEEF;
    step(); idle();
    chk("oor_bypass", 1, rs_o[1], 16'h0000);
    chk("oor_rt", 1, rt_o[1], 16'h0005);
    chk("full_bypass", 0, rs_o[0], 16'hBEEF);
    issue_en = 1; issue_idx = 7; rd_en = 1; rs_idx = 7; rt_idx = 7;
    step(); idle();
    chk("oor_read", 1, rs_o[1], 16'h0000);
    rd_en = 1; rs_idx = 7; rt_idx = 7;
    #1;
    chk("oor_nobusy", 1, 16'(hz_o[1]), 16'h0);
    chk("full_busy7", 0, 16'(hz_o[0]), 16'h1);
    step(); idle();
    chk("oor_valid", 1, 16'(vld_o[1]), 16'h1);

    // Randomized traffic checked by the model every cycle.
    repeat (3000) begin
      rd_en     = ($urandom_range(0, 9) < 6);
      wb_en     = ($urandom_range(0, 9) < 3);
      issue_en  = ($urandom_range(0, 9) < 2);
      cmp_en    = ($urandom_range(0, 1) == 1);
      sr_clr    = ($urandom_range(0, 9) == 0);
      hilo_we   = ($urandom_range(0, 4) == 0);
      rs_idx    = 3'($urandom_range(0, 7));
      rt_idx    = ($urandom_range(0, 3) == 0) ? rs_idx : 3'($urandom_range(0, 7));
      wb_idx    = ($urandom_range(0, 2) == 0) ? rs_idx : 3'($urandom_range(0, 7));
      issue_idx = 3'($urandom_range(0, 7));
      wb_data   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4)) : 16'($urandom);
      hi_in     = 16'($urandom);
      lo_in     = 16'($urandom);
      step();
    end
    idle();
    repeat (3) step();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
